// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, with a carry register between chunks.
// Latency: N = WIDTH/CHUNK cycles from the accept edge to the done pulse. Throughput is one operation per N+1 cycles,
//          or back-to-back when start is asserted on the done cycle.
// Backpressure: start is accepted only while busy=0. A start seen while busy is dropped and is not queued.
//
// Ports:
//   i_clk, i_rst            rising-edge clock; synchronous active-high reset
//   i_start                 request, accepted when o_busy=0
//   i_sub                   0: a+b+cin, 1: a+~b+1 (cin ignored); sampled at accept
//   i_a, i_b, i_cin         operands and carry-in, sampled at accept
//   o_busy                  operation in progress
//   o_done                  one-cycle pulse when the result is valid
//   o_sum, o_cout           result and carry out of the MSB (sub mode: 1 = no borrow); held until next completion
//   o_overflow              signed overflow: carry into MSB xor carry out of MSB
// WIDTH must be a multiple of CHUNK.
module seq_chunk_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    // The operand registers shift right by CHUNK after each step, so the
    // current chunk is always in the low CHUNK bits. This avoids a wide
    // variable-index mux on both operands.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [IDXW-1:0]  r_cnt;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic [CHUNK:0]   w_chunk;
    logic [CHUNK-1:0] w_s;
    logic             w_c;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_acc_next;

    // One chunk of the ripple: {c, s} = A[i] + B[i] + carry.
    assign w_chunk = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    assign w_s     = w_chunk[CHUNK-1:0];
    assign w_c     = w_chunk[CHUNK];

    // Carry into the top bit of this chunk, recovered from the sum bit.
    // Only meaningful on the last chunk, where that bit is the operand MSB.
    assign w_c_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_s[CHUNK-1];

    // New chunks enter at the top of the accumulator and shift down.
    // After N steps, chunk 0 sits in the low bits and chunk N-1 in the high bits.
    assign w_acc_next = WIDTH'({w_s, r_acc} >> CHUNK);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if (w_accept) begin
                r_a     <= i_a;
                r_b     <= i_sub ? ~i_b : i_b;
                r_carry <= i_sub ? 1'b1 : i_cin;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_carry <= w_c;
                r_acc   <= w_acc_next;
                r_cnt   <= r_cnt + IDXW'(1);
                if (w_last) begin
                    r_sum  <= w_acc_next;
                    r_cout <= w_c;
                    r_ovf  <= w_c ^ w_c_msb;
                    r_cnt  <= '0;
                end
            end
        end
    end

    assign o_busy     = (r_state == RUN);
    assign o_done     = r_done;
    assign o_sum      = r_sum;
    assign o_cout     = r_cout;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder: directed and random operations on 64/8, 1/1, 64/1, 64/16 and 64/64 instances.
// Expected results are pushed to per-instance queues at issue and popped when done pulses, including the done cycle.
// A done with nothing queued is reported as an unexpected completion.
module tb_seq_chunk_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic [31:0] due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    exp_t q_exp [5][$];

    // Main instance: 64/8
    logic        m_start, m_sub, m_cin;
    logic [63:0] m_a, m_b;
    logic        m_busy, m_done, m_cout, m_ovf;
    logic [63:0] m_sum;

    // Full-adder instance: 1/1
    logic        fa_start, fa_sub, fa_a, fa_b, fa_cin;
    logic        fa_busy, fa_done, fa_sum, fa_cout, fa_ovf;

    // Sweep instances share their operand inputs
    logic        sw_start, sw_sub, sw_cin;
    logic [63:0] sw_a, sw_b;
    logic        c1_busy, c1_done, c1_cout, c1_ovf;
    logic        c16_busy, c16_done, c16_cout, c16_ovf;
    logic        c64_busy, c64_done, c64_cout, c64_ovf;
    logic [63:0] c1_sum, c16_sum, c64_sum;

    seq_chunk_adder #(.WIDTH(64), .CHUNK(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(m_start), .i_sub(m_sub), .i_a(m_a), .i_b(m_b), .i_cin(m_cin),
        .o_busy(m_busy), .o_done(m_done), .o_sum(m_sum), .o_cout(m_cout), .o_overflow(m_ovf));

    seq_chunk_adder #(.WIDTH(1), .CHUNK(1)) u_fa (
        .i_clk(clk), .i_rst(rst), .i_start(fa_start), .i_sub(fa_sub), .i_a(fa_a), .i_b(fa_b), .i_cin(fa_cin),
        .o_busy(fa_busy), .o_done(fa_done), .o_sum(fa_sum), .o_cout(fa_cout), .o_overflow(fa_ovf));

    seq_chunk_adder #(.WIDTH(64), .CHUNK(1)) u_c1 (
        .i_clk(clk), .i_rst(rst), .i_start(sw_start), .i_sub(sw_sub), .i_a(sw_a), .i_b(sw_b), .i_cin(sw_cin),
        .o_busy(c1_busy), .o_done(c1_done), .o_sum(c1_sum), .o_cout(c1_cout), .o_overflow(c1_ovf));

    seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) u_c16 (
        .i_clk(clk), .i_rst(rst), .i_start(sw_start), .i_sub(sw_sub), .i_a(sw_a), .i_b(sw_b), .i_cin(sw_cin),
        .o_busy(c16_busy), .o_done(c16_done), .o_sum(c16_sum), .o_cout(c16_cout), .o_overflow(c16_ovf));

    seq_chunk_adder #(.WIDTH(64), .CHUNK(64)) u_c64 (
        .i_clk(clk), .i_rst(rst), .i_start(sw_start), .i_sub(sw_sub), .i_a(sw_a), .i_b(sw_b), .i_cin(sw_cin),
        .o_busy(c64_busy), .o_done(c64_done), .o_sum(c64_sum), .o_cout(c64_cout), .o_overflow(c64_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pops the oldest expectation for instance id and compares result and done cycle.
    task automatic mon(input int id, input logic [63:0] s, input logic co, input logic ov);
        exp_t e;
        n_total++;
        assert (q_exp[id].size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_done_d%0d observed done=1 expected done=0", id);
        end
        if (q_exp[id].size() != 0) begin
            e = q_exp[id].pop_front();
            chk($sformatf("sum_d%0d", id), s, e.sum);
            chk($sformatf("cout_d%0d", id), 64'(co), 64'(e.cout));
            chk($sformatf("ovf_d%0d", id), 64'(ov), 64'(e.ovf));
            chk($sformatf("done_cycle_d%0d", id), 64'(cyc), 64'(e.due));
        end
    endtask

    always @(negedge clk) begin
        if (m_done)   mon(0, m_sum, m_cout, m_ovf);
        if (fa_done)  mon(1, {63'd0, fa_sum}, fa_cout, fa_ovf);
        if (c1_done)  mon(2, c1_sum, c1_cout, c1_ovf);
        if (c16_done) mon(3, c16_sum, c16_cout, c16_ovf);
        if (c64_done) mon(4, c64_sum, c64_cout, c64_ovf);
    end

    // Independent 64-bit reference: a full 65-bit add plus a 63-bit add for the carry into the MSB.
    function automatic exp_t model64(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        exp_t        e;
        logic [63:0] bb;
        logic        c0;
        logic [64:0] full;
        logic [63:0] low;
        bb   = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + 65'(c0);
        low  = {1'b0, a[62:0]} + {1'b0, bb[62:0]} + 64'(c0);
        e.sum  = full[63:0];
        e.cout = full[64];
        e.ovf  = low[63] ^ full[64];
        e.due  = '0;
        return e;
    endfunction

    // Called at a negedge; the following posedge accepts. Returns one negedge later.
    task automatic issue_main(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                              input logic [63:0] es, input logic ec, input logic eo);
        exp_t e;
        m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_start = 1'b1;
        e.sum = es; e.cout = ec; e.ovf = eo; e.due = 32'(cyc + 1 + 8);
        q_exp[0].push_back(e);
        @(negedge clk);
        m_start = 1'b0;
    endtask

    task automatic wait_drain(input int id, input int limit, input string tag);
        int k;
        k = 0;
        while (q_exp[id].size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        assert (q_exp[id].size() == 0) else begin
            n_bad++;
            $error("FAIL %s observed pending=%0d expected pending=0", tag, q_exp[id].size());
        end
    endtask

    task automatic wait_done_main(input int limit, input string tag);
        int k;
        k = 0;
        while (m_done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(m_done), 64'd1);
    endtask

    initial begin
        exp_t e;
        logic [2:0] fav;
        logic [1:0] tot;

        rst = 1'b1;
        m_start = 1'b0; m_sub = 1'b0; m_cin = 1'b0; m_a = '0; m_b = '0;
        fa_start = 1'b0; fa_sub = 1'b0; fa_a = 1'b0; fa_b = 1'b0; fa_cin = 1'b0;
        sw_start = 1'b0; sw_sub = 1'b0; sw_cin = 1'b0; sw_a = '0; sw_b = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 64'(m_busy), 64'd0);
        chk("rst_done", 64'(m_done), 64'd0);
        chk("rst_sum", m_sum, 64'd0);
        chk("rst_cout", 64'(m_cout), 64'd0);
        chk("rst_ovf", 64'(m_ovf), 64'd0);
        chk("rst_busy_others", 64'({fa_busy, c1_busy, c16_busy, c64_busy}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ripple across all chunks
        issue_main(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        chk("busy_after_accept", 64'(m_busy), 64'd1);
        chk("sum_held_while_busy", m_sum, 64'd0);
        wait_drain(0, 20, "ripple_all_ones");
        issue_main(64'h0000_0000_0000_00FF, 64'd1, 1'b0, 1'b0, 64'h100, 1'b0, 1'b0);
        wait_drain(0, 20, "ripple_ff");

        // Subtract
        issue_main(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        wait_drain(0, 20, "sub_5_7");
        issue_main(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        wait_drain(0, 20, "sub_min_1");

        // Start while busy is dropped, including on the last-chunk edge
        issue_main(64'h1234, 64'h1111, 1'b0, 1'b0, 64'h2345, 1'b0, 1'b0);
        m_a = 64'hDEAD; m_b = 64'hBEEF; m_cin = 1'b1;
        @(negedge clk); m_start = 1'b1;
        @(negedge clk); m_start = 1'b0;
        @(negedge clk); m_start = 1'b1;
        @(negedge clk); m_start = 1'b0;
        repeat (3) @(negedge clk);
        m_start = 1'b1;
        @(negedge clk); m_start = 1'b0;
        repeat (12) @(negedge clk);
        wait_drain(0, 1, "ignored_start");
        chk("busy_after_ignored", 64'(m_busy), 64'd0);

        // Back-to-back: start asserted on the done cycle
        issue_main(64'd10, 64'd20, 1'b1, 1'b0, 64'd31, 1'b0, 1'b0);
        wait_done_main(20, "b2b_first_done");
        issue_main(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        chk("b2b_busy", 64'(m_busy), 64'd1);
        wait_drain(0, 20, "b2b_second");

        // Reset mid-operation, with a carry propagating through the chunks
        m_a = 64'hFFFF_FFFF_FFFF_FFFF; m_b = 64'd0; m_cin = 1'b1; m_sub = 1'b0; m_start = 1'b1;
        @(negedge clk); m_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(m_busy), 64'd0);
        chk("midrst_done", 64'(m_done), 64'd0);
        chk("midrst_sum", m_sum, 64'd0);
        chk("midrst_cout", 64'(m_cout), 64'd0);
        chk("midrst_ovf", 64'(m_ovf), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        issue_main(64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0);
        wait_drain(0, 20, "after_midrst");

        // Exhaustive full adder
        for (int i = 0; i < 8; i++) begin
            fav = 3'(i);
            fa_a = fav[2]; fa_b = fav[1]; fa_cin = fav[0];
            tot = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);
            e.sum  = 64'(tot[0]);
            e.cout = tot[1];
            e.ovf  = fa_cin ^ tot[1];
            e.due  = 32'(cyc + 1 + 1);
            q_exp[1].push_back(e);
            fa_start = 1'b1;
            @(negedge clk);
            fa_start = 1'b0;
            wait_drain(1, 5, $sformatf("fa_%0d", i));
        end

        // Chunk-size sweep against the reference model
        for (int i = 0; i < 8; i++) begin
            sw_a   = {$urandom(), $urandom()};
            sw_b   = {$urandom(), $urandom()};
            sw_cin = 1'($urandom_range(0, 1));
            sw_sub = 1'($urandom_range(0, 1));
            if (i == 0) begin
                sw_a = 64'hFFFF_FFFF_FFFF_FFFF; sw_b = 64'd0; sw_cin = 1'b1; sw_sub = 1'b0;
            end
            if (i == 1) begin
                sw_a = 64'h8000_0000_0000_0000; sw_b = 64'd1; sw_sub = 1'b1;
            end
            e = model64(sw_a, sw_b, sw_cin, sw_sub);
            e.due = 32'(cyc + 1 + 64); q_exp[2].push_back(e);
            e.due = 32'(cyc + 1 + 4);  q_exp[3].push_back(e);
            e.due = 32'(cyc + 1 + 1);  q_exp[4].push_back(e);
            sw_start = 1'b1;
            @(negedge clk);
            sw_start = 1'b0;
            wait_drain(2, 100, $sformatf("sweep_c1_%0d", i));
            wait_drain(3, 1, $sformatf("sweep_c16_%0d", i));
            wait_drain(4, 1, $sformatf("sweep_c64_%0d", i));
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
